// File: rtl/mips_pkg.sv
// Shared constants and types for the P7 MIPS pipeline.
package mips_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } seq_state_t;

endpackage

// File: rtl/redirect_buf.sv
// Holds one branch redirect that arrived while fetch was stalled.
module redirect_buf (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic        set,
  input  logic [31:0] set_tgt,
  input  logic        consume,
  output logic        pend,
  output logic [31:0] pend_tgt
);

  // A newer stalled branch overwrites the target; flush beats everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      pend     <= 1'b0;
      pend_tgt <= 32'h0;
    end else if (flush) begin
      pend     <= 1'b0;
    end else if (set) begin
      pend     <= 1'b1;
      pend_tgt <= set_tgt;
    end else if (consume) begin
      pend     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC and arbitrates reset, interrupt, eret,
// stall and branch redirects; flags illegal fetch addresses.
module fetch_seq #(
  parameter logic [31:0] PC_RESET   = mips_pkg::PC_RESET,
  parameter logic [31:0] HANDLER_PC = mips_pkg::HANDLER_PC,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        intreq,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc8,
  output logic [11:0] imem_idx,
  output logic        fetch_exc,
  output logic [4:0]  exc_code,
  output logic        in_handler,
  output logic        redir_pend
);

  import mips_pkg::*;

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IMEM_WORDS) - 32'd4;

  seq_state_t  state_q, state_d;
  logic [31:0] pc_d;
  logic        buf_flush, buf_set, buf_consume;
  logic        pend;
  logic [31:0] pend_tgt;

  redirect_buf u_redirect_buf (
    .clk      (clk),
    .clr      (clr),
    .flush    (buf_flush),
    .set      (buf_set),
    .set_tgt  (br_target),
    .consume  (buf_consume),
    .pend     (pend),
    .pend_tgt (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= NORMAL;
      pc      <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
    end
  end

  // Redirect priority: interrupt (NORMAL only), eret, stall, branch, pending.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc + 32'd4;
    buf_flush   = 1'b0;
    buf_set     = 1'b0;
    buf_consume = 1'b0;
    if (intreq && (state_q == NORMAL)) begin
      pc_d      = HANDLER_PC;
      state_d   = HANDLER;
      buf_flush = 1'b1;
    end else if (eret) begin
      pc_d      = epc;
      state_d   = NORMAL;
      buf_flush = 1'b1;
    end else if (stall) begin
      pc_d    = pc;
      buf_set = br_valid;
    end else if (br_valid) begin
      pc_d        = br_target;
      buf_consume = 1'b1;
    end else if (pend) begin
      pc_d        = pend_tgt;
      buf_consume = 1'b1;
    end
  end

  // Address-derived outputs depend on the registered pc only.
  always_comb begin
    pc8       = pc + 32'd8;
    imem_idx  = 12'((pc - PC_RESET) >> 2);
    fetch_exc = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc > PC_LAST);
    exc_code  = fetch_exc ? EXC_ADEL : 5'd0;
  end

  assign in_handler = (state_q == HANDLER);
  assign redir_pend = pend;

endmodule
